input_tile_scheduler: RTL and testbench

Sequences the input transform stage for one layer. It walks every channel id and every block pair, and issues paired address requests with current_id, block_cnt and size_type to the input data path. It keeps one memory request outstanding and applies PE back-pressure. It counts transformed tiles returned on both PE streams and pulses done once the last stream-2 tile has been delivered.

---
 rtl/input_tile_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_input_tile_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_tile_scheduler.sv
// Input transform scheduler: walks channel ids and block pairs, keeps one
// memory request in flight, counts PE returns and flags layer completion.
module input_tile_scheduler #(
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] block_cnt_i,
  input  logic [ID_W-1:0]   last_id_i,
  input  logic              size_type_i,
  input  logic              stall_i,
  input  logic              input_valid_i,
  input  logic              pe_valid_1_i,
  input  logic              pe_valid_2_i,
  output logic [ADDR_W-1:0] input_addr_o_1,
  output logic [ADDR_W-1:0] input_addr_o_2,
  output logic [ID_W-1:0]   current_id_o,
  output logic [ADDR_W-1:0] block_cnt_o,
  output logic              size_type_o,
  output logic              input_request_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ID_W-1:0]   I_ONE = ID_W'(1);
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] bcnt_q, bcnt_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic              size_q, size_d;

  logic [ADDR_W-1:0] pair_q, pair_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;

  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  ret1_q, ret1_d;
  logic [CNT_W-1:0]  ret2_q, ret2_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pairs;
  logic [ADDR_W-1:0] pair_addr;
  logic              last_pair;
  logic              req;
  logic              done;

  assign pairs     = (bcnt_q + A_ONE) >> 1;
  assign pair_addr = base_q + {pair_q[ADDR_W-2:0], 1'b0};
  assign last_pair = (pair_q == pairs - A_ONE) && (id_q == last_id_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    bcnt_d    = bcnt_q;
    last_id_d = last_id_q;
    size_d    = size_q;
    pair_d    = pair_q;
    id_d      = id_q;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    cur_id_d  = cur_id_q;
    issued_d  = issued_q;
    ret1_d    = ret1_q;
    ret2_d    = ret2_q;
    err_d     = err_q;
    req       = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          bcnt_d    = block_cnt_i;
          last_id_d = last_id_i;
          size_d    = size_type_i;
          pair_d    = '0;
          id_d      = '0;
          issued_d  = '0;
          ret1_d    = '0;
          ret2_d    = '0;
          state_d   = (block_cnt_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall_i) begin
          req      = 1'b1;
          issued_d = issued_q + C_ONE;
          addr1_d  = pair_addr;
          addr2_d  = pair_addr + A_ONE;
          cur_id_d = id_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (input_valid_i) begin
          if (pair_q < pairs - A_ONE) begin
            pair_d = pair_q + A_ONE;
          end else begin
            pair_d = '0;
            id_d   = id_q + I_ONE;
          end
          state_d = last_pair ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (ret2_q == issued_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // returns may land in the same cycle as a request, so compare to issued_d
    if (state_q != S_IDLE) begin
      if (pe_valid_1_i) ret1_d = ret1_q + C_ONE;
      if (pe_valid_2_i) ret2_d = ret2_q + C_ONE;
      if ((ret1_d > issued_d) || (ret2_d > issued_d)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      bcnt_q    <= '0;
      last_id_q <= '0;
      size_q    <= 1'b0;
      pair_q    <= '0;
      id_q      <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      cur_id_q  <= '0;
      issued_q  <= '0;
      ret1_q    <= '0;
      ret2_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      bcnt_q    <= bcnt_d;
      last_id_q <= last_id_d;
      size_q    <= size_d;
      pair_q    <= pair_d;
      id_q      <= id_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      cur_id_q  <= cur_id_d;
      issued_q  <= issued_d;
      ret1_q    <= ret1_d;
      ret2_q    <= ret2_d;
      err_q     <= err_d;
    end
  end

  // the _d values equal the held registers except in the request cycle
  assign input_addr_o_1  = addr1_d;
  assign input_addr_o_2  = addr2_d;
  assign current_id_o    = cur_id_d;
  assign block_cnt_o     = bcnt_q;
  assign size_type_o     = size_q;
  assign input_request_o = req;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done;
  assign error_o         = err_q;

endmodule

// File: tb/tb_input_tile_scheduler.sv
// Bench for input_tile_scheduler: memory/PE responder plus an address
// scoreboard, one task per scenario.
module tb_input_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [7:0] base_addr_i;
  logic [7:0] block_cnt_i;
  logic [3:0] last_id_i;
  logic       size_type_i;
  logic       stall_i;
  logic       input_valid_i;
  logic       pe_valid_1_i;
  logic       pe_valid_2_i;
  logic [7:0] input_addr_o_1;
  logic [7:0] input_addr_o_2;
  logic [3:0] current_id_o;
  logic [7:0] block_cnt_o;
  logic       size_type_o;
  logic       input_request_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;

  input_tile_scheduler #(.ADDR_W(8), .ID_W(4), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .base_addr_i(base_addr_i), .block_cnt_i(block_cnt_i),
    .last_id_i(last_id_i), .size_type_i(size_type_i),
    .stall_i(stall_i), .input_valid_i(input_valid_i),
    .pe_valid_1_i(pe_valid_1_i), .pe_valid_2_i(pe_valid_2_i),
    .input_addr_o_1(input_addr_o_1), .input_addr_o_2(input_addr_o_2),
    .current_id_o(current_id_o), .block_cnt_o(block_cnt_o),
    .size_type_o(size_type_o), .input_request_o(input_request_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [3:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  logic hold_ok = 1'b0;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_req = 0, n_done = 0, n_valid = 0;
  int done_cyc = -1, pe2_cyc = -1;

  logic [7:0] sched_v = '0, sched_p1 = '0, sched_p2 = '0;
  logic       reset_nx = 1'b0, start_nx = 1'b0, stall_nx = 1'b0;
  logic       xvalid_nx = 1'b0, xpe2_nx = 1'b0;
  logic [7:0] base_nx = '0, bcnt_nx = '0;
  logic [3:0] lid_nx = '0;
  logic       size_nx = 1'b0;

  task automatic push_layer(input logic [7:0] base,
                            input logic [7:0] cnt,
                            input logic [3:0] lid);
    logic [7:0] pairs, a;
    exp_t e;
    pairs = (cnt + 8'd1) >> 1;
    for (int id = 0; id <= int'(lid); id++) begin
      for (int p = 0; p < int'(pairs); p++) begin
        a = base + 8'(2 * p);
        e.a1 = a;
        e.a2 = a + 8'd1;
        e.id = 4'(id);
        sb.push_back(e);
      end
    end
  endtask

  task automatic set_cfg(input logic [7:0] base, input logic [7:0] cnt,
                         input logic [3:0] lid, input logic sz);
    base_nx  = base;
    bcnt_nx  = cnt;
    lid_nx   = lid;
    size_nx  = sz;
    start_nx = 1'b1;
  endtask

  // One clock: drive after the edge, sample at the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset         = reset_nx;
    start_i       = start_nx;
    base_addr_i   = base_nx;
    block_cnt_i   = bcnt_nx;
    last_id_i     = lid_nx;
    size_type_i   = size_nx;
    stall_i       = stall_nx;
    input_valid_i = sched_v[0] | xvalid_nx;
    pe_valid_1_i  = sched_p1[0];
    pe_valid_2_i  = sched_p2[0] | xpe2_nx;
    if (sched_v[0]) n_valid++;
    if (pe_valid_2_i) pe2_cyc = cyc;
    sched_v  = sched_v >> 1;
    sched_p1 = sched_p1 >> 1;
    sched_p2 = sched_p2 >> 1;
    start_nx  = 1'b0;
    xvalid_nx = 1'b0;
    xpe2_nx   = 1'b0;
    if (reset_nx) begin
      sched_v  = '0;
      sched_p1 = '0;
      sched_p2 = '0;
      hold_ok  = 1'b0;
    end
    @(negedge clk);
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (input_request_o) begin
      n_req++;
      sched_v[0]  = 1'b1;
      sched_p1[2] = 1'b1;
      sched_p2[3] = 1'b1;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got request %h/%h id %h, none expected",
                 input_addr_o_1, input_addr_o_2, current_id_o);
      end else begin
        e = sb.pop_front();
        if ({input_addr_o_1, input_addr_o_2, current_id_o} !== e) begin
          n_fail++;
          $display("FAIL req_addr: got %h/%h id %h, expected %h/%h id %h",
                   input_addr_o_1, input_addr_o_2, current_id_o,
                   e.a1, e.a2, e.id);
        end
        last_e  = e;
        hold_ok = 1'b1;
      end
    end else if (hold_ok && busy_o && !reset) begin
      n_chk++;
      if ({input_addr_o_1, input_addr_o_2, current_id_o} !== last_e) begin
        n_fail++;
        $display("FAIL addr_hold: got %h/%h id %h, expected %h/%h id %h",
                 input_addr_o_1, input_addr_o_2, current_id_o,
                 last_e.a1, last_e.a2, last_e.id);
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    n_chk++;
    if (n_done == d0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_nx = 1'b1;
    step();
    step();
    reset_nx = 1'b0;
    step();
    n_chk++;
    if ({input_addr_o_1, input_addr_o_2, current_id_o, block_cnt_o,
         size_type_o, input_request_o, busy_o, done_o, error_o} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b req=%b, expected all 0",
               busy_o, done_o, error_o, input_request_o);
    end
  endtask

  task automatic test_nominal();
    int r0, d0;
    r0 = n_req;
    d0 = n_done;
    push_layer(8'h10, 8'd4, 4'd1);
    set_cfg(8'h10, 8'd4, 4'd1, 1'b1);
    step();
    step();
    n_chk++;
    if ({block_cnt_o, size_type_o, busy_o} !== {8'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL nom_latch: got bcnt=%0d size=%b busy=%b, expected 4 1 1",
               block_cnt_o, size_type_o, busy_o);
    end
    run_until_done(200);
    n_chk++;
    if (n_req - r0 != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL nom_reqs: got %0d requests (%0d left), expected 4 (0 left)",
               n_req - r0, sb.size());
    end
    n_chk++;
    if (done_cyc != pe2_cyc + 2) begin
      n_fail++;
      $display("FAIL nom_done_time: got cycle %0d, expected %0d",
               done_cyc, pe2_cyc + 2);
    end
    step();
    n_chk++;
    if ({busy_o, done_o, error_o} !== 3'b000 || block_cnt_o !== 8'd4) begin
      n_fail++;
      $display("FAIL nom_after: got busy=%b done=%b err=%b bcnt=%0d, expected 0 0 0 4",
               busy_o, done_o, error_o, block_cnt_o);
    end
    for (int i = 0; i < 4; i++) step();
    n_chk++;
    if (n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL nom_done_count: got %0d pulses, expected 1", n_done - d0);
    end
  endtask

  task automatic test_odd_wrap();
    int r0;
    r0 = n_req;
    push_layer(8'hFE, 8'd3, 4'd0);
    set_cfg(8'hFE, 8'd3, 4'd0, 1'b0);
    step();
    run_until_done(200);
    n_chk++;
    if (n_req - r0 != 2 || sb.size() != 0 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reqs: got %0d requests (%0d left) err=%b, expected 2 (0 left) 0",
               n_req - r0, sb.size(), error_o);
    end
    step();
  endtask

  task automatic test_empty();
    int r0, s;
    r0 = n_req;
    set_cfg(8'h40, 8'd0, 4'd3, 1'b1);
    step();
    s = cyc;
    n_chk++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_early: got done=%b in start cycle, expected 0", done_o);
    end
    step();
    n_chk++;
    if (done_o !== 1'b1 || done_cyc != s + 1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_done: got done=%b at cycle %0d busy=%b, expected 1 at %0d busy 1",
               done_o, done_cyc, busy_o, s + 1);
    end
    step();
    n_chk++;
    if (busy_o !== 1'b0 || n_req != r0 || block_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL empty_after: got busy=%b reqs=%0d bcnt=%0d, expected 0 0 0",
               busy_o, n_req - r0, block_cnt_o);
    end
  endtask

  task automatic test_stall_ignore();
    int r0;
    xvalid_nx = 1'b1;
    step();
    step();
    n_chk++;
    if ({busy_o, input_request_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_valid: got busy=%b req=%b done=%b, expected 0 0 0",
               busy_o, input_request_o, done_o);
    end
    r0 = n_req;
    push_layer(8'h20, 8'd2, 4'd0);
    set_cfg(8'h20, 8'd2, 4'd0, 1'b0);
    stall_nx = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) xvalid_nx = 1'b1;
      step();
      n_chk++;
      if (input_request_o !== 1'b0 || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_req: cycle %0d got req=%b busy=%b, expected 0 1",
                 i, input_request_o, busy_o);
      end
    end
    stall_nx = 1'b0;
    step();
    n_chk++;
    if (input_request_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got req=%b, expected 1", input_request_o);
    end
    set_cfg(8'h99, 8'd9, 4'd2, 1'b1);
    step();
    bcnt_nx = 8'd2;
    run_until_done(200);
    n_chk++;
    if (n_req - r0 != 1 || sb.size() != 0 || block_cnt_o !== 8'd2 ||
        size_type_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start: got %0d reqs bcnt=%0d size=%b, expected 1 2 0",
               n_req - r0, block_cnt_o, size_type_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    r0 = n_req;
    d0 = n_done;
    push_layer(8'h10, 8'd4, 4'd1);
    set_cfg(8'h10, 8'd4, 4'd1, 1'b1);
    step();
    for (int i = 0; i < 100 && n_req - r0 < 3; i++) step();
    reset_nx = 1'b1;
    step();
    reset_nx = 1'b0;
    step();
    n_chk++;
    if ({input_addr_o_1, input_addr_o_2, current_id_o, block_cnt_o,
         size_type_o, input_request_o, busy_o, done_o, error_o} !== 33'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got a=%h/%h id=%h bcnt=%0d busy=%b, expected all 0",
               input_addr_o_1, input_addr_o_2, current_id_o, block_cnt_o, busy_o);
    end
    n_chk++;
    if (n_req - r0 != 3 || n_done != d0) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d reqs %0d dones, expected 3 0",
               n_req - r0, n_done - d0);
    end
    sb.delete();
    r0 = n_req;
    push_layer(8'h10, 8'd4, 4'd1);
    set_cfg(8'h10, 8'd4, 4'd1, 1'b1);
    step();
    run_until_done(200);
    n_chk++;
    if (n_req - r0 != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL restart_reqs: got %0d requests (%0d left), expected 4 (0 left)",
               n_req - r0, sb.size());
    end
    step();
  endtask

  task automatic test_error();
    int v0;
    v0 = n_valid;
    push_layer(8'h00, 8'd4, 4'd0);
    set_cfg(8'h00, 8'd4, 4'd0, 1'b0);
    step();
    for (int i = 0; i < 100 && n_valid - v0 < 2; i++) step();
    n_chk++;
    if (n_valid - v0 != 2) begin
      n_fail++;
      $display("FAIL err_setup: got %0d memory valids, expected 2", n_valid - v0);
    end
    step();
    step();
    step();
    xpe2_nx = 1'b1;
    step();
    n_chk++;
    if ({error_o, busy_o, done_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL err_pre: got err=%b busy=%b done=%b, expected 0 1 0",
               error_o, busy_o, done_o);
    end
    step();
    n_chk++;
    if ({error_o, done_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_rise: got err=%b done=%b, expected 1 1", error_o, done_o);
    end
    for (int i = 0; i < 4; i++) step();
    n_chk++;
    if ({error_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b busy=%b, expected 1 0", error_o, busy_o);
    end
    reset_nx = 1'b1;
    step();
    reset_nx = 1'b0;
    step();
    n_chk++;
    if (error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b, expected 0", error_o);
    end
  endtask

  initial begin
    reset         = 1'b1;
    start_i       = 1'b0;
    base_addr_i   = '0;
    block_cnt_i   = '0;
    last_id_i     = '0;
    size_type_i   = 1'b0;
    stall_i       = 1'b0;
    input_valid_i = 1'b0;
    pe_valid_1_i  = 1'b0;
    pe_valid_2_i  = 1'b0;
    test_reset();
    test_nominal();
    test_odd_wrap();
    test_empty();
    test_stall_ignore();
    test_reset_mid();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
